h75_fb_loader: RTL and testbench
================================

# h75_fb_loader

Framebuffer write loader between the APB control/status register block and the HUB75 driver's pixel memory write port. It accepts pixel words pushed by register writes and buffers them in a small FIFO. Each word is tagged with an auto-incrementing framebuffer address. The FIFO drains onto the driver's `wr_en`/`wr_addr`/`wr_data` port either continuously or only in a burst window opened by the driver's `frame_sync` pulse, which avoids visible tearing.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..64.
- `FB_WORDS`, 24576: framebuffer size in words; address wraps from `FB_WORDS-1` to 0; must be ≤ 32768.
- `clk` input 1: single clock, driven from PCLK.
- `reset` input 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `s_valid` input 1: pixel word offered.
- `s_ready` output 1: high when the FIFO is not full; a word is accepted on `s_valid & s_ready`.
- `s_data` input 32: pixel word.
- `addr_load` input 1: one-cycle pulse; loads the write pointer.
- `addr_value` input 15: new write pointer value.
- `sync_en` input 1: 1 = drain only in frame-sync windows; 0 = drain continuously.
- `frame_sync` input 1: one-cycle pulse from the driver at each frame start.
- `wr_en` output 1: framebuffer write strobe.
- `wr_addr` output 15: framebuffer write address.
- `wr_data` output 32: framebuffer write data.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.
- `overflow` output 1: sticky; set when `s_valid & !s_ready`; cleared by `addr_load` or `reset`.
- `wr_count` output 16: words written since the last `addr_load`; saturates at 16'hFFFF.

## Operation
- **Input side.** Write pointer `ptr` (15 bits, reset 0).
  - On accept, push {`ptr`, `s_data`}, then set `ptr` ← `ptr`+1, or 0 if `ptr` = `FB_WORDS-1`.
  - `addr_load` in the same cycle as an accept: the word takes `addr_value`, and `ptr` ← `addr_value`+1 (with wrap).
  - `addr_load` alone: `ptr` ← `addr_value`.
  - `addr_value` ≥ `FB_WORDS` is clamped to 0.
- **Overflow.** `s_valid` while full: the word is dropped, `overflow` sets, and `ptr` does not advance.
- **Drain FSM.** States are CONT, WAIT_SYNC and BURST.
  - CONT (`sync_en`=0): pop whenever the FIFO is non-empty.
  - `sync_en` rising in CONT: go to WAIT_SYNC. In WAIT_SYNC nothing pops.
  - `frame_sync` in WAIT_SYNC: go to BURST. In BURST, pop every cycle while non-empty.
  - FIFO empty in BURST, with no push that cycle: return to WAIT_SYNC.
  - `sync_en`=0 seen in WAIT_SYNC or BURST: go to CONT.
  - `frame_sync` in BURST or CONT: ignored.
- **Output.** Each pop produces exactly one `wr_en` cycle carrying the stored address and data. `wr_count` increments on each `wr_en`.
- **Push and pop in the same cycle.** Allowed when not full. `level` is unchanged.
- **Full at cycle start.** `s_ready`=0 even if a pop occurs in that cycle; there is no full-bypass.

## Timing
- `s_ready` = !full, registered; it reflects the occupancy at the start of the cycle.
- **Latency.** A word accepted at cycle N, with the FIFO empty and in CONT, gives `wr_en` at N+2 (registered FIFO read plus registered output stage).
- **Burst latency.** `frame_sync` at cycle M with the FIFO non-empty (WAIT_SYNC) gives the first `wr_en` at M+2.
- Throughput is 1 word/cycle sustained.
- Every cycle `wr_en`=0, `wr_addr` and `wr_data` hold their last values.
- **Reset values.**
  - `s_ready`=0 during reset, 1 on the cycle after reset deasserts.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `level`=0, `overflow`=0, `wr_count`=0.
  - FSM = CONT, `ptr`=0.
- **Reset mid-operation.** The FIFO is flushed, no `wr_en` is emitted from the cycle reset is sampled, and in-flight data is discarded.
- **Wrap.** `ptr` = `FB_WORDS-1` accepted → next word addr 0.

## Structure
- Package `h75_pkg` holds:
  - `FB_ADDR_W` = 15 and `PIX_W` = 32.
  - The FSM enum `drain_state_t` {CONT, WAIT_SYNC, BURST}.
  - The packed entry struct `fb_wr_t` {addr, data}.
- Sub-module `h75_sync_fifo`: synchronous FIFO with parameter `DEPTH`, width `$bits(fb_wr_t)`, registered read, `full`/`empty`/`level`.
- The top contains the pointer, FSM, output register and counters.

## Test plan
- **Continuous:** reset, `sync_en`=0, `addr_load` 0x0100, push 3 words A,B,C back-to-back → `wr_en` at N+2..N+4 with addr 0x100/0x101/0x102 and data A/B/C; `wr_count`=3.
- **Wrap:** `addr_load` `FB_WORDS-1` (0x5FFF), push 2 words → addresses 0x5FFF then 0x0000.
- **Overflow:** `sync_en`=1, no `frame_sync`, push 17 words → `s_ready`=0 after the 16th, 17th dropped, `overflow`=1, `level`=16, no `wr_en`. Then `frame_sync` → 16 consecutive `wr_en` cycles starting 2 cycles later; FSM returns to WAIT_SYNC; `level`=0.
- **Simultaneous:** `addr_load` 0x0200 in the same cycle as accepting word X → X written at 0x200, next word at 0x201.
- **Reset mid-burst:** 8 words queued, `frame_sync`, assert `reset` after 3 writes → no further `wr_en`, all outputs at reset values, `level`=0. Words pushed after reset start at addr 0.
- **Saturation and clear:** force `wr_count` to 0xFFFF, perform 1 more write → stays 0xFFFF; `addr_load` → `wr_count`=0, `overflow`=0.

Source files
------------

// File: rtl/h75_pkg.sv
// Shared types and constants for the HUB75 framebuffer write loader.
package h75_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int PIX_W     = 32;

    localparam logic [FB_ADDR_W-1:0] ADDR_ONE = {{(FB_ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        CONT      = 2'd0,
        WAIT_SYNC = 2'd1,
        BURST     = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]     data;
    } fb_wr_t;

    // Framebuffer address increment that wraps after the last word.
    function automatic logic [FB_ADDR_W-1:0] fb_next_addr(
        input logic [FB_ADDR_W-1:0] cur,
        input logic [FB_ADDR_W-1:0] last
    );
        return (cur == last) ? {FB_ADDR_W{1'b0}} : (cur + ADDR_ONE);
    endfunction

endpackage

// File: rtl/h75_sync_fifo.sv
// Single-clock FIFO with a registered read port and occupancy count.
module h75_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 47
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] pop_data_r;
    logic             pop_valid_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = pop_data_r;
    assign pop_valid = pop_valid_r;
    assign level     = count_r;

    // Storage array write port; contents need no reset since reads are gated by count.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the registered read stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {(AW+1){1'b0}};
            pop_data_r  <= {WIDTH{1'b0}};
            pop_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                pop_data_r <= mem_r[rd_ptr_r];
            end
            count_r     <= count_r + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
            pop_valid_r <= pop_ok_s;
        end
    end

endmodule

// File: rtl/h75_fb_loader.sv
// Buffers register-pushed pixel words and drains them into the HUB75 pixel
// memory either continuously or in bursts opened by frame_sync.
module h75_fb_loader
    import h75_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int FB_WORDS = 24576
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [31:0]            s_data,
    input  logic                   addr_load,
    input  logic [14:0]            addr_value,
    input  logic                   sync_en,
    input  logic                   frame_sync,
    output logic                   wr_en,
    output logic [14:0]            wr_addr,
    output logic [31:0]            wr_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [15:0]            wr_count
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]        FULL_LVL  = LW'(DEPTH);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);
    localparam logic [FB_ADDR_W:0]   WORDS_W   = (FB_ADDR_W+1)'(FB_WORDS);

    drain_state_t         state_r, state_next_s;
    logic [FB_ADDR_W-1:0] ptr_r, ptr_next_s, addr_clamp_s;
    logic                 s_ready_r, overflow_r, wr_en_r;
    logic [FB_ADDR_W-1:0] wr_addr_r;
    logic [PIX_W-1:0]     wr_data_r;
    logic [15:0]          wr_count_r;
    fb_wr_t               push_entry_s, pop_entry_s;
    logic                 accept_s, pop_s, pop_valid_s, fifo_full_s, fifo_empty_s;
    logic [LW-1:0]        fifo_level_s, level_next_s;

    h75_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fb_wr_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .pop_data  (pop_entry_s),
        .pop_valid (pop_valid_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level_s)
    );

    // Input side: acceptance, address tagging and write-pointer update.
    always_comb begin
        addr_clamp_s      = ({1'b0, addr_value} >= WORDS_W) ? {FB_ADDR_W{1'b0}} : addr_value;
        accept_s          = s_valid & s_ready_r & ~fifo_full_s;
        push_entry_s.data = s_data;
        if (addr_load) begin
            push_entry_s.addr = addr_clamp_s;
        end else begin
            push_entry_s.addr = ptr_r;
        end
        if (accept_s) begin
            ptr_next_s = fb_next_addr(push_entry_s.addr, LAST_ADDR);
        end else if (addr_load) begin
            ptr_next_s = addr_clamp_s;
        end else begin
            ptr_next_s = ptr_r;
        end
        pop_s        = ~fifo_empty_s & (state_r != WAIT_SYNC);
        level_next_s = fifo_level_s + {{(LW-1){1'b0}}, accept_s} - {{(LW-1){1'b0}}, pop_s};
    end

    // Drain mode sequencing; frame_sync only matters while waiting for a window.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CONT: begin
                if (sync_en) state_next_s = WAIT_SYNC;
                else         state_next_s = CONT;
            end
            WAIT_SYNC: begin
                if (!sync_en)       state_next_s = CONT;
                else if (frame_sync) state_next_s = BURST;
                else                state_next_s = WAIT_SYNC;
            end
            BURST: begin
                if (!sync_en)                      state_next_s = CONT;
                else if (fifo_empty_s && !accept_s) state_next_s = WAIT_SYNC;
                else                               state_next_s = BURST;
            end
            default: state_next_s = CONT;
        endcase
    end

    // State, status flags, output stage and write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= CONT;
            ptr_r      <= {FB_ADDR_W{1'b0}};
            s_ready_r  <= 1'b0;
            overflow_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {FB_ADDR_W{1'b0}};
            wr_data_r  <= {PIX_W{1'b0}};
            wr_count_r <= 16'h0000;
        end else begin
            state_r   <= state_next_s;
            ptr_r     <= ptr_next_s;
            s_ready_r <= (level_next_s != FULL_LVL);
            if (addr_load) begin
                overflow_r <= 1'b0;
            end else if (s_valid && !s_ready_r) begin
                overflow_r <= 1'b1;
            end
            wr_en_r <= pop_valid_s;
            if (pop_valid_s) begin
                wr_addr_r <= pop_entry_s.addr;
                wr_data_r <= pop_entry_s.data;
            end
            if (addr_load) begin
                wr_count_r <= 16'h0000;
            end else if (pop_valid_s && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'h0001;
            end
        end
    end

    assign s_ready  = s_ready_r;
    assign overflow = overflow_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign wr_count = wr_count_r;
    assign level    = fifo_level_s;

endmodule

// File: tb/tb_h75_fb_loader.sv
// Directed self-checking bench for h75_fb_loader.
module tb_h75_fb_loader;

    logic        clk = 1'b0;
    logic        reset, s_valid, addr_load, sync_en, frame_sync;
    logic [31:0] s_data;
    logic [14:0] addr_value;
    logic        s_ready, wr_en, overflow;
    logic [14:0] wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  level;
    logic [15:0] wr_count;

    int checks = 0;
    int errors = 0;

    h75_fb_loader #(.DEPTH(16), .FB_WORDS(24576)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .addr_load(addr_load), .addr_value(addr_value),
        .sync_en(sync_en), .frame_sync(frame_sync), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .level(level),
        .overflow(overflow), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [14:0] av;
        logic [31:0] d;
        logic [14:0] ea;
        logic [15:0] ec;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push1(input logic ld, input logic [14:0] av, input logic [31:0] d);
        s_valid = 1'b1; addr_load = ld; addr_value = av; s_data = d;
        tick();
        s_valid = 1'b0; addr_load = 1'b0;
    endtask

    // Wait (bounded) for a wr_en cycle and check its address/data.
    task automatic wait_wr(input int max, input logic [14:0] ea, input logic [31:0] ed, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            if (wr_en) seen = 1'b1;
            else tick();
        end
        chk({name, "_seen"}, 64'(seen), 64'(1));
        if (seen) begin
            chk({name, "_addr"}, 64'(wr_addr), 64'(ea));
            chk({name, "_data"}, 64'(wr_data), 64'(ed));
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ab_c [3];
        ab_c[0] = 32'hAAAA_0001; ab_c[1] = 32'hBBBB_0002; ab_c[2] = 32'hCCCC_0003;
        tbl[0] = '{1'b1, 15'h0100, 32'h1111_0000, 15'h0100, 16'd1};
        tbl[1] = '{1'b0, 15'h0000, 32'h2222_0000, 15'h0101, 16'd2};
        tbl[2] = '{1'b0, 15'h0000, 32'h3333_0000, 15'h0102, 16'd3};
        tbl[3] = '{1'b1, 15'h5FFF, 32'h4444_0000, 15'h5FFF, 16'd1};
        tbl[4] = '{1'b0, 15'h0000, 32'h5555_0000, 15'h0000, 16'd2};
        tbl[5] = '{1'b1, 15'h0200, 32'h6666_0000, 15'h0200, 16'd1};
        tbl[6] = '{1'b0, 15'h0000, 32'h7777_0000, 15'h0201, 16'd2};
        tbl[7] = '{1'b1, 15'h7000, 32'h8888_0000, 15'h0000, 16'd1};
        tbl[8] = '{1'b0, 15'h0000, 32'h9999_0000, 15'h0001, 16'd2};

        reset = 1'b1; s_valid = 1'b0; addr_load = 1'b0; addr_value = 15'h0;
        s_data = 32'h0; sync_en = 1'b0; frame_sync = 1'b0;
        tick(); tick(); tick();
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_wr_count", 64'(wr_count), 64'(0));
        reset = 1'b0;
        tick();
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));

        // Back-to-back continuous pushes: writes at N+2..N+4.
        for (int k = 0; k < 7; k++) begin
            s_valid = (k < 3); addr_load = (k == 0); addr_value = 15'h0100;
            s_data = (k < 3) ? ab_c[k] : 32'h0;
            if (k >= 3 && k <= 5) begin
                chk("b2b_wr_en", 64'(wr_en), 64'(1));
                chk("b2b_addr", 64'(wr_addr), 64'(15'h0100 + 15'(k - 3)));
                chk("b2b_data", 64'(wr_data), 64'(ab_c[k-3]));
            end else begin
                chk("b2b_idle", 64'(wr_en), 64'(0));
            end
            tick();
        end
        s_valid = 1'b0; addr_load = 1'b0;
        chk("b2b_count", 64'(wr_count), 64'(3));

        // Table: isolated single pushes with exact-latency checks.
        for (int v = 0; v < 9; v++) begin
            push1(tbl[v].ld, tbl[v].av, tbl[v].d);
            tick();
            chk("tbl_early", 64'(wr_en), 64'(0));
            tick();
            chk("tbl_wr_en", 64'(wr_en), 64'(1));
            chk("tbl_addr", 64'(wr_addr), 64'(tbl[v].ea));
            chk("tbl_data", 64'(wr_data), 64'(tbl[v].d));
            chk("tbl_count", 64'(wr_count), 64'(tbl[v].ec));
            tick();
            chk("tbl_single", 64'(wr_en), 64'(0));
        end

        // Overflow while waiting for frame_sync, then one full burst.
        sync_en = 1'b1;
        tick(); tick();
        for (int k = 0; k < 17; k++) begin
            chk("ovf_s_ready", 64'(s_ready), 64'(k < 16));
            chk("ovf_no_wr", 64'(wr_en), 64'(0));
            s_valid = 1'b1; addr_load = (k == 0); addr_value = 15'h1000;
            s_data = 32'hA000_0000 + 32'(k);
            tick();
        end
        s_valid = 1'b0; addr_load = 1'b0;
        chk("ovf_level", 64'(level), 64'(16));
        chk("ovf_flag", 64'(overflow), 64'(1));
        chk("ovf_s_ready_full", 64'(s_ready), 64'(0));
        frame_sync = 1'b1;
        for (int j = 0; j < 19; j++) begin
            tick();
            frame_sync = 1'b0;
            chk("burst_wr_en", 64'(wr_en), 64'(j >= 2 && j <= 17));
            if (j >= 2 && j <= 17) begin
                chk("burst_addr", 64'(wr_addr), 64'(15'h1000 + 15'(j - 2)));
                chk("burst_data", 64'(wr_data), 64'(32'hA000_0000 + 32'(j - 2)));
            end
        end
        chk("burst_level", 64'(level), 64'(0));

        // Back in WAIT_SYNC: a new word must be held until the mode changes.
        push1(1'b0, 15'h0, 32'hDEAD_0010);
        for (int j = 0; j < 6; j++) begin
            chk("rewait_no_wr", 64'(wr_en), 64'(0));
            tick();
        end
        chk("rewait_level", 64'(level), 64'(1));
        sync_en = 1'b0;
        wait_wr(8, 15'h1010, 32'hDEAD_0010, "to_cont");

        // addr_load alone clears overflow and count, then sets the pointer.
        tick();
        addr_load = 1'b1; addr_value = 15'h0300;
        tick();
        addr_load = 1'b0;
        chk("clr_overflow", 64'(overflow), 64'(0));
        chk("clr_count", 64'(wr_count), 64'(0));
        push1(1'b0, 15'h0, 32'h0300_BEEF);
        wait_wr(6, 15'h0300, 32'h0300_BEEF, "load_alone");
        tick(); tick();

        // Reset in the middle of a burst.
        sync_en = 1'b1;
        tick(); tick();
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1; addr_load = (k == 0); addr_value = 15'h0400;
            s_data = 32'hB000_0000 + 32'(k);
            tick();
        end
        s_valid = 1'b0; addr_load = 1'b0;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("mid_wr_en", 64'(wr_en), 64'(1));
            chk("mid_addr", 64'(wr_addr), 64'(15'h0400 + 15'(j)));
        end
        reset = 1'b1; sync_en = 1'b0;
        tick();
        chk("mid_rst_wr_en", 64'(wr_en), 64'(0));
        chk("mid_rst_addr", 64'(wr_addr), 64'(0));
        chk("mid_rst_data", 64'(wr_data), 64'(0));
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_count", 64'(wr_count), 64'(0));
        chk("mid_rst_s_ready", 64'(s_ready), 64'(0));
        tick();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("post_rst_no_wr", 64'(wr_en), 64'(0));
        end
        chk("post_rst_level", 64'(level), 64'(0));
        push1(1'b0, 15'h0, 32'hC0DE_0000);
        wait_wr(6, 15'h0000, 32'hC0DE_0000, "post_rst_push");
        tick(); tick();

        // Counter saturation.
        addr_load = 1'b1; addr_value = 15'h0000;
        tick();
        addr_load = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            s_data = 32'(i);
            tick();
        end
        s_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("sat_reach", 64'(wr_count), 64'(16'hFFFF));
        chk("sat_level", 64'(level), 64'(0));
        chk("sat_no_ovf", 64'(overflow), 64'(0));
        push1(1'b0, 15'h0, 32'h5A5A_5A5A);
        wait_wr(6, 15'(65535 % 24576), 32'h5A5A_5A5A, "sat_extra");
        tick();
        chk("sat_hold", 64'(wr_count), 64'(16'hFFFF));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
